// File: rtl/fetch_unit_buf_pkg.sv
// Shared definitions for the fetch unit slice.
//   - Default widths, PC step and reset PC used by the interface and the top.
//   - Fetch-entry width (instruction + PC).
//   - Request-tracking state encoding.
package fetch_unit_buf_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned INST_W_DEF   = 32;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned FENTRY_W_DEF = INST_W_DEF + XLEN_DEF;

  // FS_IDLE : nothing in flight
  // FS_WAIT : one request in flight, its response will be buffered
  // FS_DROP : one request in flight, its response is stale and will be dropped
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_buf_if.sv
// Fetch unit bus bundle: ICache request/response, IQ output and ROB redirect.
//   master : fetch unit side (drives ICache request and IQ entry)
//   slave  : environment side (ICache, IQ and ROB)
interface fetch_unit_buf_if
  import fetch_unit_buf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned INST_W = INST_W_DEF
);

  logic              icache_req_valid;
  logic [XLEN-1:0]   icache_req_addr;
  logic              icache_req_ready;
  logic              icache_rsp_valid;
  logic [INST_W-1:0] icache_rsp_inst;
  logic              iq_valid;
  logic [INST_W-1:0] iq_inst;
  logic [XLEN-1:0]   iq_pc;
  logic              iq_ready;
  logic              redirect_en;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output icache_req_valid, icache_req_addr, iq_valid, iq_inst, iq_pc,
    input  icache_req_ready, icache_rsp_valid, icache_rsp_inst, iq_ready,
           redirect_en, redirect_pc
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, iq_valid, iq_inst, iq_pc,
    output icache_req_ready, icache_rsp_valid, icache_rsp_inst, iq_ready,
           redirect_en, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_buf_fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, PC} entries.
//   clk, rst        : clock, asynchronous active-high reset (clears contents too)
//   flush           : empty the FIFO (pointers/count), has priority over push/pop
//   push, push_data : write at tail (ignored when full)
//   pop, pop_data   : pop_data is the head entry; pop advances head (ignored when empty)
//   count/full/empty: occupancy
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[head_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + AW'(1);
      end
      if (do_pop) begin
        head_d = head_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit_buf.sv
// Instruction fetch unit with fetch buffer between ICache and IQ.
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-high reset
//   rdy_in : global ready, 0 freezes all state and masks both valids
//   bus    : master side of fetch_unit_buf_if (ICache req/rsp, IQ, redirect)
// Keeps at most one ICache request in flight and reserves a buffer slot for it,
// so the buffer can never overflow. A redirect flushes the buffer and marks an
// in-flight request stale so its response is dropped.
module fetch_unit_buf
  import fetch_unit_buf_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     INST_W     = INST_W_DEF,
  parameter int unsigned     FBUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int unsigned     PC_STEP    = PC_STEP_DEF
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  fetch_unit_buf_if.master bus
);

  localparam int unsigned CW = $clog2(FBUF_DEPTH) + 1;
  localparam int unsigned EW = INST_W + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic          outstanding, discard;
  logic          req_valid, accept, iq_valid;
  logic          push, pop, flush;
  logic [CW-1:0] count, fill_lvl;
  logic          full, empty;
  logic [EW-1:0] head_entry;

  assign outstanding = (state_q != FS_IDLE);
  assign discard     = (state_q == FS_DROP);
  assign fill_lvl    = count + CW'(outstanding);

  assign req_valid = ~rst_in & rdy_in & ~bus.redirect_en & ~outstanding & ~discard &
                     ~full & (fill_lvl < CW'(FBUF_DEPTH));
  assign accept    = req_valid & bus.icache_req_ready;
  assign iq_valid  = ~rst_in & rdy_in & ~bus.redirect_en & ~empty;

  assign push  = rdy_in & ~bus.redirect_en & bus.icache_rsp_valid & (state_q == FS_WAIT);
  assign pop   = iq_valid & bus.iq_ready;
  assign flush = rdy_in & bus.redirect_en;

  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = fetch_pc_q;
  assign bus.iq_valid         = iq_valid;
  assign bus.iq_inst          = head_entry[EW-1:XLEN];
  assign bus.iq_pc            = head_entry[XLEN-1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (rdy_in) begin
      if (bus.redirect_en) begin
        fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
        // A response landing with the redirect retires the in-flight request
        // (stale or not); otherwise an in-flight request becomes stale.
        if (outstanding) begin
          state_d = bus.icache_rsp_valid ? FS_IDLE : FS_DROP;
        end
      end else if (accept) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        state_d    = FS_WAIT;
      end else if (bus.icache_rsp_valid && outstanding) begin
        state_d = FS_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FBUF_DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .flush    (flush),
    .push     (push),
    .push_data({bus.icache_rsp_inst, req_pc_q}),
    .pop      (pop),
    .pop_data (head_entry),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: doc/fetch_unit_buf.md
Name: fetch_unit_buf

Overview:
Parametrised instruction fetch unit with an internal fetch buffer, sitting between the ICache and the Instruction Queue (IQ). It keeps one ICache request outstanding and buffers up to FBUF_DEPTH fetched instructions, each paired with its PC. On a ROB redirect it flushes the buffer and discards any stale in-flight response, so fetch continues at the new PC with no lost cycles beyond the flush.

Parameters:
XLEN, 32, PC/address width.
INST_W, 32, instruction width.
FBUF_DEPTH, 4, fetch buffer entries; power of 2, minimum 2.
RESET_PC, 0, fetch PC after reset.
PC_STEP, 4, PC increment per fetched instruction.

Ports:
clk_in  in  1  clock, rising edge.
rst_in  in  1  asynchronous reset, active-high.
rdy_in  in  1  global ready; 0 freezes the block.
icache_req_valid  out  1  fetch request valid (combinational).
icache_req_addr  out  XLEN  fetch address; always equals fetch_pc.
icache_req_ready  in  1  ICache accepts the request this cycle.
icache_rsp_valid  in  1  instruction returned for the outstanding request.
icache_rsp_inst  in  INST_W  returned instruction.
iq_valid  out  1  buffer head valid toward IQ.
iq_inst  out  INST_W  head instruction.
iq_pc  out  XLEN  head PC.
iq_ready  in  1  IQ not full; pop when iq_valid & iq_ready.
redirect_en  in  1  ROB redirect (mispredict/jump commit).
redirect_pc  in  XLEN  redirect target.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, count=0, head/tail=0, outstanding=0, discard=0, buffer contents=0, so iq_inst=0 and iq_pc=0. During reset icache_req_valid=0 and iq_valid=0.
- rdy_in=0: all registers hold; icache_req_valid=0; iq_valid=0. The ICache does not present responses and the ROB does not redirect while rdy_in=0; the block ignores both inputs in that state.
- icache_req_valid = rdy_in & ~redirect_en & ~outstanding & ~discard & ((count + outstanding) < FBUF_DEPTH).
- Request acceptance (valid & ready): req_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP (mod 2^XLEN), outstanding <= 1.
- ICache response latency is ≥1 cycle after acceptance. Responses return in order, one per request.
- Response with outstanding=1 & discard=0 & ~redirect_en: push {icache_rsp_inst, req_pc} at tail; outstanding <= 0. A new request may not issue in the same cycle; the next request issues the following cycle.
- Response with discard=1: drop it; outstanding <= 0; discard <= 0.
- IQ pop: iq_valid = rdy_in & ~redirect_en & (count != 0). Outputs are the head entry. A pop advances head. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, rdy_in=1): count, head and tail <= 0; fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; no push and no pop.
  - If outstanding and no response this cycle: discard <= 1, outstanding stays 1.
  - If a response arrives this cycle: drop it, outstanding <= 0, discard unchanged.
  - If discard is already 1: it stays 1.
- Full boundary: count=FBUF_DEPTH never occurs with outstanding=1, because the issue rule reserves a slot for the in-flight response. Overflow is impossible.
- Empty boundary: iq_valid=0, and iq_inst/iq_pc show the stale head entry (don't-care).
- Pointers wrap modulo FBUF_DEPTH. count is $clog2(FBUF_DEPTH)+1 bits wide.

Decomposition:
- Shared defines header (alongside `InstSize/`REGSize): XLEN, INST_W, PC_STEP, RESET_PC defaults, and the fetch-entry width INST_W+XLEN.
- One sub-module: fetch_fifo. It is a synchronous FIFO with parameters DEPTH and WIDTH, async reset, a flush input, push/pop, and count, full and empty outputs.
- fetch_unit_buf holds the PC, the outstanding/discard state and the request/redirect control.

Test Plan:
1. Reset released, rdy_in=1, icache_req_ready=1 → icache_req_valid=1 with addr=0x0 in the first cycle; iq_valid=0.
2. ICache with 1-cycle latency returning inst=0x1000+pc, iq_ready=1 → IQ receives (pc,inst) = (0x0,0x1000), (0x4,0x1004), (0x8,0x1008) in order, one every 2 cycles.
3. iq_ready=0, FBUF_DEPTH=4 → 4 entries buffered (pc 0x0..0xC); icache_req_valid stays 0 once count+outstanding=4. Raising iq_ready → pop pc 0x0, and a request for 0x10 issues the next cycle.
4. Request for 0x8 accepted, redirect_en with redirect_pc=0x103 next cycle, response arrives the cycle after → response dropped; discard=1 then 0; next request addr=0x100; first IQ pc=0x100.
5. Redirect to 0x200 in the same cycle as a response → response dropped, discard stays 0, request for 0x200 issued next cycle, buffer empty.
6. rdy_in=0 for 3 cycles mid-stream with 2 entries buffered → icache_req_valid=0 and iq_valid=0, state frozen; after rdy_in=1 the same head (pc/inst) is presented and the sequence continues unchanged.
7. Assert rst_in asynchronously mid-stream → outputs go to reset values without a clock edge; addr=RESET_PC.
